// File: rtl/tree_adder_pkg.sv
// Shared defaults and width/extension helpers for the pipelined adder tree.
package tree_adder_pkg;

  localparam int TA_NUM_IN    = 4;
  localparam int TA_IN_W      = 8;
  localparam int TA_ACC_EXTRA = 4;
  localparam int TA_SIGNED    = 0;

  function automatic int ta_out_w(int num_in, int in_w, int acc_extra);
    return in_w + $clog2(num_in) + acc_extra;
  endfunction

  function automatic logic [63:0] ta_mask(int w);
    if (w >= 64) return '1;
    return (64'd1 << w) - 64'd1;
  endfunction

  // Sign- or zero-extends the low from_w bits of value to to_w bits.
  function automatic logic [63:0] ta_ext(logic [63:0] value, int from_w, int to_w,
                                         int signed_mode);
    logic [63:0] r;
    logic        sgn;
    r   = value & ta_mask(from_w);
    sgn = ((value >> (from_w - 1)) & 64'd1) != 64'd0;
    if (signed_mode != 0 && sgn) r = r | ~ta_mask(from_w);
    return r & ta_mask(to_w);
  endfunction

endpackage

// File: rtl/tree_adder_stage.sv
// One adder-tree level: N/2 full-precision pairwise adds, registered with
// the beat's valid bit and {acc_en, last} sideband.
module tree_adder_stage
  import tree_adder_pkg::*;
#(
  parameter int N      = 4,
  parameter int W      = 8,
  parameter int SIGNED = 0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  input  logic [N*W-1:0]         in_vals,
  input  logic                   in_valid,
  input  logic [1:0]             in_side,
  output logic [(N/2)*(W+1)-1:0] out_vals,
  output logic                   out_valid,
  output logic [1:0]             out_side
);

  logic [(N/2)*(W+1)-1:0] sums;

  for (genvar j = 0; j < N / 2; j++) begin : g_add
    logic [W-1:0] a, b;
    logic         sa, sb;
    assign a  = in_vals[(2*j)*W +: W];
    assign b  = in_vals[(2*j+1)*W +: W];
    assign sa = (SIGNED != 0) & a[W-1];
    assign sb = (SIGNED != 0) & b[W-1];
    assign sums[j*(W+1) +: W+1] = {sa, a} + {sb, b};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_vals  <= '0;
      out_valid <= 1'b0;
      out_side  <= 2'b00;
    end else if (en) begin
      out_vals  <= sums;
      out_valid <= in_valid;
      out_side  <= in_side;
    end
  end

endmodule

// File: rtl/tree_adder_pipelined.sv
// Pipelined NUM_IN-input adder tree with valid/ready flow control and a
// multi-beat accumulate mode. in_ready depends combinationally on out_ready.
module tree_adder_pipelined
  import tree_adder_pkg::*;
#(
  parameter  int NUM_IN    = TA_NUM_IN,
  parameter  int IN_W      = TA_IN_W,
  parameter  int ACC_EXTRA = TA_ACC_EXTRA,
  parameter  int SIGNED    = TA_SIGNED,
  localparam int LOG2N     = $clog2(NUM_IN),
  localparam int OUT_W     = ta_out_w(NUM_IN, IN_W, ACC_EXTRA)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_IN*IN_W-1:0] in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   acc_en,
  input  logic                   in_last,
  output logic [OUT_W-1:0]       out_sum,
  output logic                   out_ovf,
  output logic                   out_valid,
  input  logic                   out_ready
);

  logic adv;
  assign adv      = !(out_valid && !out_ready);
  assign in_ready = adv;

  // Level 0 is the raw input; level k is the output of tree stage k.
  for (genvar k = 0; k <= LOG2N; k++) begin : g_lvl
    logic [(NUM_IN>>k)*(IN_W+k)-1:0] d;
    logic                            v;
    logic [1:0]                      s;
    if (k == 0) begin : g_in
      assign d = in_data;
      assign v = in_valid;
      assign s = {acc_en, acc_en & in_last};
    end else begin : g_stg
      tree_adder_stage #(
        .N      (NUM_IN >> (k - 1)),
        .W      (IN_W + k - 1),
        .SIGNED (SIGNED)
      ) u_stage (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (adv),
        .in_vals   (g_lvl[k-1].d),
        .in_valid  (g_lvl[k-1].v),
        .in_side   (g_lvl[k-1].s),
        .out_vals  (d),
        .out_valid (v),
        .out_side  (s)
      );
    end
  end

  logic [IN_W+LOG2N-1:0] t_tree;
  logic                  t_valid, t_acc, t_last;
  logic [OUT_W-1:0]      t_ext;
  assign t_tree  = g_lvl[LOG2N].d;
  assign t_valid = g_lvl[LOG2N].v;
  assign t_acc   = g_lvl[LOG2N].s[1];
  assign t_last  = g_lvl[LOG2N].s[0];
  assign t_ext   = OUT_W'(ta_ext(64'(t_tree), IN_W + LOG2N, OUT_W, SIGNED));

  logic [OUT_W-1:0] acc, base, sum;
  logic             open, sticky, ovf_add;
  logic [OUT_W:0]   wide;

  assign base = open ? acc : '0;
  assign wide = {1'b0, base} + {1'b0, t_ext};
  assign sum  = wide[OUT_W-1:0];
  assign ovf_add = (SIGNED != 0)
                 ? ((base[OUT_W-1] == t_ext[OUT_W-1]) && (sum[OUT_W-1] != base[OUT_W-1]))
                 : wide[OUT_W];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_sum   <= '0;
      out_ovf   <= 1'b0;
      out_valid <= 1'b0;
      acc       <= '0;
      open      <= 1'b0;
      sticky    <= 1'b0;
    end else if (adv) begin
      if (!t_valid) begin
        out_valid <= 1'b0;
      end else if (!t_acc) begin
        out_sum   <= t_ext;
        out_ovf   <= 1'b0;
        out_valid <= 1'b1;
      end else if (!t_last) begin
        acc       <= sum;
        open      <= 1'b1;
        sticky    <= sticky | ovf_add;
        out_valid <= 1'b0;
      end else begin
        out_sum   <= sum;
        out_ovf   <= sticky | ovf_add;
        out_valid <= 1'b1;
        acc       <= '0;
        open      <= 1'b0;
        sticky    <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_tree_adder_pipelined.sv
// Drives three tree_adder_pipelined configurations (unsigned, ACC_EXTRA=0, signed)
// from one stimulus stream and scoreboards each against a behavioural model.
module tb_tree_adder_pipelined;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] in_data = '0;
  logic        in_valid = 1'b0, acc_en = 1'b0, in_last = 1'b0, out_ready = 1'b1;

  logic        in_ready_a, in_ready_b, in_ready_c;
  logic [9:0]  out_sum_a, out_sum_c;
  logic [5:0]  out_sum_b;
  logic        out_ovf_a, out_ovf_b, out_ovf_c;
  logic        out_valid_a, out_valid_b, out_valid_c;

  always #5 clk = ~clk;

  tree_adder_pipelined #(.NUM_IN(4), .IN_W(4), .ACC_EXTRA(4), .SIGNED(0)) u_a (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready_a),
    .acc_en(acc_en), .in_last(in_last), .out_sum(out_sum_a), .out_ovf(out_ovf_a),
    .out_valid(out_valid_a), .out_ready(out_ready));
  tree_adder_pipelined #(.NUM_IN(4), .IN_W(4), .ACC_EXTRA(0), .SIGNED(0)) u_b (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready_b),
    .acc_en(acc_en), .in_last(in_last), .out_sum(out_sum_b), .out_ovf(out_ovf_b),
    .out_valid(out_valid_b), .out_ready(out_ready));
  tree_adder_pipelined #(.NUM_IN(4), .IN_W(4), .ACC_EXTRA(4), .SIGNED(1)) u_c (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready_c),
    .acc_en(acc_en), .in_last(in_last), .out_sum(out_sum_c), .out_ovf(out_ovf_c),
    .out_valid(out_valid_c), .out_ready(out_ready));

  typedef struct { logic [63:0] sum; logic ovf; } exp_t;
  typedef struct { logic [15:0] d; logic acc; logic last; logic [63:0] es; logic eo; } vec_t;

  exp_t qa[$], qb[$], qc[$];
  int total = 0, bad = 0;

  int          ow[3] = '{10, 6, 10};
  int          sg[3] = '{0, 0, 1};
  logic [63:0] m_acc[3];
  bit          m_open[3], m_sticky[3];

  function automatic logic [15:0] pk(int a0, int a1, int a2, int a3);
    return {4'(a3), 4'(a2), 4'(a1), 4'(a0)};
  endfunction

  task automatic check(string name, logic [63:0] got, logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h @%0t", name, got, want, $time);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 3; i++) begin
      m_acc[i] = '0; m_open[i] = 0; m_sticky[i] = 0;
    end
  endtask

  task automatic model_beat(input logic [15:0] d, input logic acc, input logic last,
                            input bit use_tab, input logic [63:0] tsum, input logic tovf);
    for (int idx = 0; idx < 3; idx++) begin
      longint      t;
      logic [63:0] mask, tm, base, s, r;
      logic        o, produce;
      exp_t        e;
      t = 0;
      for (int i = 0; i < 4; i++) begin
        int v;
        v = int'(4'(d >> (4 * i)));
        if (sg[idx] != 0 && v >= 8) t += longint'(v - 16);
        else t += longint'(v);
      end
      mask = (64'd1 << ow[idx]) - 64'd1;
      tm = 64'(t) & mask;
      produce = 0; r = '0; o = 0;
      if (!acc) begin
        r = tm; o = 0; produce = 1;
      end else begin
        base = m_open[idx] ? m_acc[idx] : 64'd0;
        s = base + tm;
        r = s & mask;
        if (sg[idx] != 0)
          o = (((base >> (ow[idx]-1)) & 1) == ((tm >> (ow[idx]-1)) & 1)) &&
              (((r >> (ow[idx]-1)) & 1) != ((base >> (ow[idx]-1)) & 1));
        else
          o = (s >> ow[idx]) != 0;
        if (!last) begin
          m_acc[idx] = r; m_open[idx] = 1; m_sticky[idx] = m_sticky[idx] | o;
        end else begin
          o = o | m_sticky[idx]; produce = 1;
          m_acc[idx] = '0; m_open[idx] = 0; m_sticky[idx] = 0;
        end
      end
      if (produce) begin
        e.sum = (idx == 0 && use_tab) ? tsum : r;
        e.ovf = (idx == 0 && use_tab) ? tovf : o;
        case (idx)
          0: qa.push_back(e);
          1: qb.push_back(e);
          default: qc.push_back(e);
        endcase
      end
    end
  endtask

  task automatic send(input logic [15:0] d, input logic acc, input logic last,
                      input bit use_tab = 0, input logic [63:0] tsum = 0, input logic tovf = 0);
    int n = 0;
    bit ok = 0;
    while (!ok && n < 300) begin
      @(negedge clk);
      in_data = d; in_valid = 1'b1; acc_en = acc; in_last = last;
      #1;
      if (in_ready_a) begin
        model_beat(d, acc, last, use_tab, tsum, tovf);
        ok = 1;
      end
      n++;
    end
    if (!ok) begin
      total++; bad++;
      $display("FAIL send_timeout got=stalled want=accepted @%0t", $time);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drain(string name);
    int n = 0;
    while ((qa.size() + qb.size() + qc.size()) != 0 && n < 200) begin
      @(negedge clk); n++;
    end
    idle(2);
    check({name, "_left_a"}, 64'(qa.size()), 0);
    check({name, "_left_b"}, 64'(qb.size()), 0);
    check({name, "_left_c"}, 64'(qc.size()), 0);
  endtask

  task automatic pop_cmp(string name, int idx, logic [63:0] sum, logic ovf);
    exp_t e;
    int sz;
    sz = (idx == 0) ? qa.size() : (idx == 1) ? qb.size() : qc.size();
    if (sz == 0) begin
      total++; bad++;
      $display("FAIL %s_unexpected got=%0h want=no_output @%0t", name, sum, $time);
    end else begin
      case (idx)
        0: e = qa.pop_front();
        1: e = qb.pop_front();
        default: e = qc.pop_front();
      endcase
      check({name, "_sum"}, sum, e.sum);
      check({name, "_ovf"}, 64'(ovf), 64'(e.ovf));
    end
  endtask

  // Output monitor: compares on every handshake, checks hold and stall behaviour.
  bit          hold_prev = 0;
  logic [63:0] h_sum_a, h_sum_c;
  logic        h_ovf_a;
  always @(negedge clk) begin
    #2;
    if (!rst_n) begin
      hold_prev = 0;
    end else begin
      if (out_valid_a && out_ready) pop_cmp("out_a", 0, 64'(out_sum_a), out_ovf_a);
      if (out_valid_b && out_ready) pop_cmp("out_b", 1, 64'(out_sum_b), out_ovf_b);
      if (out_valid_c && out_ready) pop_cmp("out_c", 2, 64'(out_sum_c), out_ovf_c);
      if (hold_prev) begin
        check("hold_sum_a", 64'(out_sum_a), h_sum_a);
        check("hold_ovf_a", 64'(out_ovf_a), 64'(h_ovf_a));
        check("hold_sum_c", 64'(out_sum_c), h_sum_c);
        check("hold_valid", 64'(out_valid_a), 1);
      end
      if (out_valid_a && !out_ready) begin
        check("stall_in_ready", 64'({in_ready_a, in_ready_b, in_ready_c}), 0);
        hold_prev = 1;
        h_sum_a = 64'(out_sum_a); h_ovf_a = out_ovf_a; h_sum_c = 64'(out_sum_c);
      end else begin
        hold_prev = 0;
      end
    end
  end

  vec_t tab[10];

  initial begin
    tab[0] = '{pk(15,15,15,15), 1'b0, 1'b0, 64'd60, 1'b0};
    tab[1] = '{pk(0,0,0,0),     1'b0, 1'b0, 64'd0,  1'b0};
    tab[2] = '{pk(1,2,3,4),     1'b0, 1'b0, 64'd10, 1'b0};
    tab[3] = '{pk(8,0,0,7),     1'b0, 1'b0, 64'd15, 1'b0};
    tab[4] = '{pk(1,2,3,4),     1'b1, 1'b0, 64'd0,  1'b0};
    tab[5] = '{pk(5,5,5,5),     1'b1, 1'b0, 64'd0,  1'b0};
    tab[6] = '{pk(1,0,0,0),     1'b0, 1'b0, 64'd1,  1'b0};
    tab[7] = '{pk(3,3,3,3),     1'b0, 1'b1, 64'd12, 1'b0};
    tab[8] = '{pk(15,15,15,15), 1'b1, 1'b1, 64'd90, 1'b0};
    tab[9] = '{pk(2,2,2,2),     1'b1, 1'b1, 64'd8,  1'b0};
    model_clear();

    #3;
    check("rst_valid", 64'({out_valid_a, out_valid_b, out_valid_c}), 0);
    check("rst_in_ready", 64'({in_ready_a, in_ready_b, in_ready_c}), 3'b111);
    check("rst_sum_a", 64'(out_sum_a), 0);
    check("rst_ovf", 64'({out_ovf_a, out_ovf_b, out_ovf_c}), 0);
    idle(2);
    rst_n = 1'b1;

    // single beat latency: accepted at edge E, visible after E+2
    send(pk(15,15,15,15), 1'b0, 1'b0);
    @(posedge clk); #1;
    check("lat_e1_valid", 64'(out_valid_a), 0);
    @(posedge clk); #1;
    check("lat_e2_valid", 64'(out_valid_a), 1);
    check("lat_e2_sum", 64'(out_sum_a), 60);
    drain("single");

    for (int i = 0; i < 10; i++)
      send(tab[i].d, tab[i].acc, tab[i].last, 1, tab[i].es, tab[i].eo);
    drain("table");

    // wrap on the ACC_EXTRA=0 instance, then a clean non-accumulate beat
    send(pk(15,15,15,15), 1'b1, 1'b0);
    send(pk(15,15,15,15), 1'b1, 1'b1);
    send(pk(1,0,0,0), 1'b0, 1'b0);
    drain("wrap");

    // signed operands on the SIGNED=1 instance
    send(pk(8,8,8,8), 1'b0, 1'b0);
    send(pk(7,8,1,0), 1'b0, 1'b0);
    drain("signed");

    // backpressure on a back-to-back stream
    fork
      begin
        for (int i = 0; i < 6; i++) send(pk(i, i+1, 2*i, 15-i), 1'b0, 1'b0);
      end
      begin
        idle(3);
        out_ready = 1'b0;
        idle(5);
        out_ready = 1'b1;
      end
    join
    drain("bp");

    // reset mid-packet discards the open accumulation
    send(pk(1,2,3,4), 1'b1, 1'b0);
    send(pk(5,5,5,5), 1'b1, 1'b0);
    idle(4);
    @(negedge clk);
    rst_n = 1'b0;
    model_clear();
    #1;
    check("midrst_valid", 64'(out_valid_a), 0);
    check("midrst_in_ready", 64'(in_ready_a), 1);
    idle(2);
    rst_n = 1'b1;
    send(pk(1,1,1,1), 1'b1, 1'b1);
    drain("midrst");

    // randomised traffic with random backpressure
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          send(16'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
          if ($urandom_range(0, 3) == 0) idle(1);
        end
        send(16'($urandom), 1'b1, 1'b1);
      end
      begin
        repeat (120) begin
          @(negedge clk);
          out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1'b1;
      end
    join
    out_ready = 1'b1;
    drain("rand");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
